// File: rtl/custom_instr_pkg.sv
// Shared types and constants for the custom-instruction coprocessor pipeline.
package custom_instr_pkg;

    localparam int unsigned WB_DEPTH   = 4;
    localparam int unsigned X_ID_WIDTH = 4;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           data;
        logic [4:0]            rd;
        logic                  we;
    } wb_entry_t;

    typedef struct packed {
        logic seen;
        logic kill;
    } commit_flags_t;

endpackage

// File: rtl/custom_result_fifo.sv
// Generic DEPTH-entry synchronous FIFO; head entry is presented combinationally.
module custom_result_fifo
    import custom_instr_pkg::*;
#(
    parameter int unsigned DEPTH   = WB_DEPTH,
    parameter type         entry_t = wb_entry_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  entry_t                     data_i,
    input  logic                       pop_i,
    output entry_t                     data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign data_o  = mem[rd_ptr];

    // Full is judged on registered count only, so a same-cycle pop never frees a slot.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/custom_wb_stage.sv
// Write-back stage: buffers ex results and releases them on the X-IF result
// channel once the core commits their id; killed results are dropped.
module custom_wb_stage
    import custom_instr_pkg::*;
#(
    parameter int unsigned DEPTH    = WB_DEPTH,
    parameter int unsigned ID_WIDTH = X_ID_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ex_valid_i,
    output logic                ex_ready_o,
    input  logic [ID_WIDTH-1:0] ex_id_i,
    input  logic [31:0]         ex_data_i,
    input  logic [4:0]          ex_rd_i,
    input  logic                ex_we_i,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [31:0]         result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                result_exc_o,
    output logic [5:0]          result_exccode_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned N_IDS = 2 ** ID_WIDTH;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [31:0]         data;
        logic [4:0]          rd;
        logic                we;
    } entry_t;

    entry_t         push_entry;
    entry_t         head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [AW:0]    fifo_count;
    logic           push;
    logic           pop;
    logic           head_committed;
    logic           head_release;
    logic           head_drop;
    commit_flags_t  head_flags;
    commit_flags_t  table_q [N_IDS];

    assign push_entry = '{id: ex_id_i, data: ex_data_i, rd: ex_rd_i, we: ex_we_i};
    assign ex_ready_o = (fifo_count != (AW+1)'(DEPTH));
    assign push       = ex_valid_i & ~fifo_full;

    custom_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_flags     = table_q[head.id];
    assign head_committed = ~fifo_empty & head_flags.seen;
    assign head_release   = head_committed & ~head_flags.kill;
    assign head_drop      = head_committed & head_flags.kill;
    assign pop            = head_drop | (head_release & result_ready_i);

    assign result_valid_o   = head_release;
    assign result_id_o      = head_release ? head.id   : '0;
    assign result_data_o    = head_release ? head.data : '0;
    assign result_rd_o      = head_release ? head.rd   : '0;
    assign result_we_o      = head_release & head.we;
    assign result_exc_o     = 1'b0;
    assign result_exccode_o = '0;

    // The clear is written last so it wins over a same-cycle commit to the popped id.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_IDS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            if (commit_valid_i) begin
                table_q[commit_id_i] <= '{seen: 1'b1, kill: commit_kill_i};
            end
            if (pop) begin
                table_q[head.id] <= '0;
            end
        end
    end

endmodule

// File: doc/custom_wb_stage.md
Name: custom_wb_stage

Overview:
- Downstream neighbour of custom_ex_stage inside coproc: buffers completed custom-instruction results and returns them to the core over the CV-X-IF result channel.
- Results are released only after the core commits the instruction id. Killed instructions are discarded silently.
- Results leave in ex-completion order.

Parameters:
- DEPTH, 4, number of result FIFO entries (power of 2, >=2).
- ID_WIDTH, 4, X-IF instruction id width; the commit table has 2**ID_WIDTH entries.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- ex_valid_i  input  1  ex stage has a completed result.
- ex_ready_o  output  1  wb stage can accept a result.
- ex_id_i  input  ID_WIDTH  id of the result.
- ex_data_i  input  32  result value.
- ex_rd_i  input  5  destination register.
- ex_we_i  input  1  result writes rd.
- commit_valid_i  input  1  commit transaction valid.
- commit_id_i  input  ID_WIDTH  committed/killed id.
- commit_kill_i  input  1  1 = kill, 0 = commit.
- result_valid_o  output  1  X-IF result valid.
- result_ready_i  input  1  X-IF result ready from core.
- result_id_o  output  ID_WIDTH  result id.
- result_data_o  output  32  result data.
- result_rd_o  output  5  result rd.
- result_we_o  output  1  result write enable.
- result_exc_o  output  1  tied 0.
- result_exccode_o  output  6  tied 0.

Behaviour:
- Reset values:
  - FIFO empty, count=0, all commit-table entries cleared.
  - ex_ready_o=1.
  - result_valid_o=0; result_id_o, result_data_o, result_rd_o and result_we_o all 0.
- Ex handshake:
  - Entry pushed on ex_valid_i & ex_ready_o.
  - ex_ready_o = (count != DEPTH), registered-state only. A pop in the same cycle does not raise ready when full; no bypass.
- Commit table:
  - Each id has two flags, {seen, kill}, captured on commit_valid_i.
  - Updates are visible to the head logic the following cycle. A commit may arrive before or after the result.
  - A repeated commit for an id already seen overwrites its kill flag.
- Head evaluation (FIFO non-empty, table[head.id].seen=1):
  - kill=0: result_valid_o=1, outputs driven combinationally from the head entry.
    - Pop and clear the table entry on result_valid_o & result_ready_i.
    - Valid and payload stay stable until the handshake.
  - kill=1: pop and clear the table entry in one cycle; result_valid_o stays 0 that cycle.
  - seen=0: stall, result_valid_o=0.
- Precedence when in one cycle a commit write and a clear of the same id collide:
  - The clear wins for the popped instance.
  - A new commit for a re-issued id is not expected in that cycle; behaviour is defined as clear-wins.
- Simultaneous push and pop:
  - Both occur; count unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - count has clog2(DEPTH)+1 bits.
- Head pointer advances only on pop.
- Reset mid-operation clears FIFO and table immediately (async); pending results are lost.

Decomposition:
- Shared package custom_instr_pkg: wb_entry_t {id, data[31:0], rd[4:0], we}, commit_flags_t {seen, kill}, WB_DEPTH and X_ID_WIDTH constants.
- Sub-module custom_result_fifo: generic DEPTH-entry sync FIFO of wb_entry_t with push/pop/full/empty/count.
- Top module holds the commit table and head-release logic. coproc instantiates custom_wb_stage after custom_ex_stage and connects xif_result and xif_commit.

Test Plan:
- Commit after result:
  - Push id=3, data=0xDEADBEEF, rd=5, we=1, then commit id=3 kill=0 two cycles later.
  - Expect result_valid_o one cycle after commit, payload {3, 0xDEADBEEF, 5, 1}; entry popped on ready.
- Commit before result: commit id=7 at cycle 0, push id=7 data=0x12 at cycle 3 -> result_valid_o=1 at cycle 4.
- Kill: push id=2, commit id=2 kill=1 -> result_valid_o never asserts, count returns to 0, next entry id=4 (committed) appears next cycle.
- Backpressure/full:
  - Push 4 entries with no commits -> ex_ready_o=0 after the 4th.
  - Commit all 4 and hold result_ready_i=0 for 5 cycles -> valid and payload stable.
  - Then ready=1 -> four results in order 1, 2, 3, 4.
- Simultaneous push/pop at count=2 -> count stays 2 and pointers wrap correctly over 10 iterations.
- Reset mid-stream with 3 entries queued and result_valid_o=1 -> outputs 0 and ex_ready_o=1 immediately; old ids never emerge after a stale commit.
